row_fetch_scheduler: RTL and testbench
======================================

# row_fetch_scheduler

Sequences full-frame processing through `subpixel_interpolation`: walks the frame in vertical blocks and generates the row-memory address that feeds the datapath's `in_row`. For each block it streams the 8-tap vertical filter window (3 rows above, 4 rows below), with edge-clamped row addresses. It waits for the datapath to finish each block before advancing, and flags frame completion. It sits between the row memory and the interpolation datapath, and replaces the free-running `next_row` counter as the row sequencer.

## Interface
- `FRAME_ROWS`, 28800: number of rows in the frame; legal range 1..2^ADDR_W.
- `ADDR_W`, 15: row-address width.
- `BLOCK_ROWS`, 8: output rows per block; each block fetches BLOCK_ROWS+7 input rows.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to process a frame; honoured only in IDLE.
- `row_addr`  out  ADDR_W  row-memory address of the row being offered.
- `row_valid`  out  1  `row_addr` is valid; the datapath should consume `im_rows[row_addr]`.
- `row_ready`  in  1  datapath accepts the offered row; a transfer occurs when `row_valid & row_ready`.
- `blk_first`  out  1  high with the first row of each block; the datapath clears its window.
- `blk_done`  in  1  one-cycle pulse: datapath finished all outputs of the current block.
- `blk_idx`  out  ADDR_W  index of the current block, starting at 0.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when the last block completes.
- `proto_err`  out  1  sticky; `blk_done` was received outside DRAIN.

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE. Registers: `base` (first output row of the block), `k` (fetch index, 0..BLOCK_ROWS+6), `blk_idx`.
- IDLE: `start` sets base=0, k=0, blk_idx=0, clears `proto_err`, and moves to FETCH.
- FETCH:
  - `row_valid`=1.
  - `row_addr` = clamp(base − 3 + k, 0, FRAME_ROWS−1). The subtraction is computed signed in ADDR_W+2 bits, then clamped.
  - `blk_first` = (k==0).
  - On transfer: if k==BLOCK_ROWS+6, go to DRAIN; otherwise k++.
  - With `row_ready` low, `row_addr` and `row_valid` hold unchanged.
- DRAIN: `row_valid`=0. On `blk_done`:
  - If base+BLOCK_ROWS ≥ FRAME_ROWS, go to DONE.
  - Otherwise base += BLOCK_ROWS, blk_idx++, k=0, and go to FETCH.
- DONE: `frame_done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. `blk_done` in IDLE, FETCH or DONE sets `proto_err` and is otherwise ignored.
- Blocks per frame = ceil(FRAME_ROWS/BLOCK_ROWS). A trailing partial block still fetches BLOCK_ROWS+7 rows; addresses past the bottom of the frame clamp to FRAME_ROWS−1.
- When `rst` goes low, in any state, the block returns immediately to IDLE and every register clears. No partial handshake survives reset.

## Timing
- Reset values: `row_addr`=0, `row_valid`=0, `blk_first`=0, `blk_idx`=0, `busy`=0, `frame_done`=0, `proto_err`=0.
- All outputs are Moore functions of registered state; there are no combinational paths from inputs to outputs.
- Start latency: with `start` sampled at edge N, `row_valid` and `busy` are high after edge N; `row_addr` is valid in the same cycle.
- Fetch throughput: one row per cycle while `row_ready`=1. With `row_ready` held high, a block takes BLOCK_ROWS+7 cycles in FETCH.
- DRAIN to FETCH: with `blk_done` at edge M, the next block's first row is offered after edge M.
- `blk_done` and the last transfer cannot coincide, because `blk_done` is only honoured in DRAIN.
- Last block: with `blk_done` at edge M, `frame_done` is high during cycle M+1, and `busy` drops after edge M+1.

## Test plan
- **Block 0 addresses and edge clamp.** FRAME_ROWS=20, BLOCK_ROWS=8, `row_ready`=1, one `start` → block 0 addresses 0,0,0,0,1,…,11 (15 transfers); `blk_first` high only with the first; then DRAIN with `row_valid`=0.
- **Full frame and bottom clamp.** Same config; pulse `blk_done` 5 cycles after each DRAIN entry → blocks 0,1,2 with bases 0,8,16; block 2 addresses 13..19, then 19 ×8; 45 transfers total; one `frame_done` pulse; `busy`=0 afterwards.
- **Backpressure.** Toggle `row_ready` with a 1-low/2-high pattern in block 1 → `row_addr` holds while `row_ready` is low; sequence 5..19 with no skips or duplicates.
- **Ignored start and protocol error.** `start` during FETCH → ignored, and `blk_idx` is unchanged. `blk_done` during FETCH → `proto_err`=1, fetch continues; the next accepted `start` clears it.
- **Reset mid-operation.** Drop `rst` low for 1 cycle at k=7 of block 1 → all outputs 0 immediately; a fresh `start` restarts at block 0, address 0.
- **Default config.** FRAME_ROWS=28800, BLOCK_ROWS=8 → 3600 blocks; last block addresses 28789..28799, then 28799 ×4; `frame_done` asserted once.

Source files
------------

// File: rtl/row_fetch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : row_fetch_scheduler_if
// Brief    : Row stream and block handshake between scheduler and datapath.
// Revision : 1.0
// ============================================================================
interface row_fetch_scheduler_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] row_addr;
    logic              row_valid;
    logic              row_ready;
    logic              blk_first;
    logic              blk_done;
    logic [ADDR_W-1:0] blk_idx;

    modport master (
        output row_addr, row_valid, blk_first, blk_idx,
        input  row_ready, blk_done
    );

    modport slave (
        input  row_addr, row_valid, blk_first, blk_idx,
        output row_ready, blk_done
    );
endinterface
`default_nettype wire

// File: rtl/row_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : row_fetch_scheduler
// Brief    : Walks a frame in vertical blocks, streaming each block's 8-tap
//            filter window as edge-clamped row addresses.
// Revision : 1.0
// ============================================================================
module row_fetch_scheduler #(
    parameter int FRAME_ROWS = 28800,
    parameter int ADDR_W     = 15,
    parameter int BLOCK_ROWS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    row_fetch_scheduler_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  proto_err
);
    localparam int c_FETCH_LEN = BLOCK_ROWS + 7;
    localparam int c_K_W       = $clog2(c_FETCH_LEN);
    localparam int c_W         = ADDR_W + 2;

    localparam logic [c_K_W-1:0]  c_K_LAST   = c_K_W'(c_FETCH_LEN - 1);
    localparam logic [c_W-1:0]    c_LAST_ROW = c_W'(FRAME_ROWS - 1);
    localparam logic [c_W-1:0]    c_FRAME    = c_W'(FRAME_ROWS);
    localparam logic [c_W-1:0]    c_BLK      = c_W'(BLOCK_ROWS);
    localparam logic [ADDR_W-1:0] c_BLK_A    = ADDR_W'(BLOCK_ROWS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  w_base_nxt;
    logic [c_K_W-1:0]   r_k;
    logic [c_K_W-1:0]   w_k_nxt;
    logic [ADDR_W-1:0]  r_blk_idx;
    logic [ADDR_W-1:0]  w_blk_idx_nxt;
    logic               r_proto_err;
    logic               w_proto_err_nxt;

    logic [c_W-1:0]        w_base_ext;
    logic signed [c_W-1:0] w_off;
    logic [ADDR_W-1:0]     w_addr_clamped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_k         <= '0;
            r_blk_idx   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_k         <= w_k_nxt;
            r_blk_idx   <= w_blk_idx_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign w_base_ext = c_W'(r_base);

    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_k_nxt         = r_k;
        w_blk_idx_nxt   = r_blk_idx;
        w_proto_err_nxt = r_proto_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_nxt      = '0;
                    w_k_nxt         = '0;
                    w_blk_idx_nxt   = '0;
                    w_proto_err_nxt = 1'b0;
                    w_state_nxt     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.row_ready) begin
                    if (r_k == c_K_LAST) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_k_nxt = r_k + c_K_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (bus.blk_done) begin
                    if (w_base_ext + c_BLK >= c_FRAME) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_base_nxt    = r_base + c_BLK_A;
                        w_blk_idx_nxt = r_blk_idx + ADDR_W'(1);
                        w_k_nxt       = '0;
                        w_state_nxt   = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A stray completion is recorded even if it coincides with an accepted start.
        if (bus.blk_done && (r_state != S_DRAIN)) begin
            w_proto_err_nxt = 1'b1;
        end
    end

    // Window starts three rows above the block; clamp to the frame edges.
    always_comb begin
        w_off = signed'(w_base_ext) + signed'(c_W'(r_k)) - signed'(c_W'(3));
        if (w_off < 0) begin
            w_addr_clamped = '0;
        end else if (w_off > signed'(c_LAST_ROW)) begin
            w_addr_clamped = c_LAST_ROW[ADDR_W-1:0];
        end else begin
            w_addr_clamped = w_off[ADDR_W-1:0];
        end
    end

    assign bus.row_valid = (r_state == S_FETCH);
    assign bus.row_addr  = (r_state == S_FETCH) ? w_addr_clamped : '0;
    assign bus.blk_first = (r_state == S_FETCH) && (r_k == '0);
    assign bus.blk_idx   = r_blk_idx;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = (r_state == S_DONE);
    assign proto_err     = r_proto_err;
endmodule
`default_nettype wire

// File: tb/tb_row_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_fetch_scheduler
// Brief    : Randomized bench for row_fetch_scheduler against a frame model.
// Revision : 1.0
// ============================================================================
module tb_row_fetch_scheduler;
    localparam int FRAME_ROWS = 20;
    localparam int BLOCK_ROWS = 8;
    localparam int ADDR_W     = 15;
    localparam int FETCH_LEN  = BLOCK_ROWS + 7;
    localparam int NBLK       = (FRAME_ROWS + BLOCK_ROWS - 1) / BLOCK_ROWS;
    localparam int TOTAL      = NBLK * FETCH_LEN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;
    logic proto_err;

    row_fetch_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    row_fetch_scheduler #(
        .FRAME_ROWS (FRAME_ROWS),
        .ADDR_W     (ADDR_W),
        .BLOCK_ROWS (BLOCK_ROWS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: how far through the frame's transfer list we are, and what phase.
    bit m_fetch, m_drain, m_fdone, m_busy, m_proto;
    int m_idx, m_dcnt;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int i);
        int a;
        a = (i / FETCH_LEN) * BLOCK_ROWS - 3 + (i % FETCH_LEN);
        if (a < 0) a = 0;
        if (a > FRAME_ROWS - 1) a = FRAME_ROWS - 1;
        return a;
    endfunction

    task automatic check_outputs();
        check("row_valid", bus.row_valid, m_fetch);
        check("busy", busy, m_busy);
        check("frame_done", frame_done, m_fdone);
        check("proto_err", proto_err, m_proto);
        if (m_fetch) begin
            check("row_addr", bus.row_addr, exp_addr(m_idx));
            check("blk_first", bus.blk_first, (m_idx % FETCH_LEN) == 0);
            check("blk_idx", bus.blk_idx, m_idx / FETCH_LEN);
        end
    endtask

    task automatic model_reset();
        m_fetch = 0; m_drain = 0; m_fdone = 0; m_busy = 0; m_proto = 0;
        m_idx = 0; m_dcnt = 0;
    endtask

    // rdy_pct < 0 selects the 1-low/2-high ready pattern; dly < 0 randomizes drain time.
    task automatic run_frame(input int rdy_pct, input int dly, input int err_pct,
                             input int start_pct, input int abort_idx);
        int  n_fd, n_xfer, cyc, d;
        bit  aborted;
        n_fd = 0; n_xfer = 0; cyc = 0; aborted = 0;
        @(negedge clk);
        check_outputs();
        start = 1'b1;
        m_fetch = 1; m_drain = 0; m_fdone = 0; m_busy = 1; m_proto = 0;
        m_idx = 0; m_dcnt = 0;
        d = (dly < 0) ? int'($urandom_range(0, 6)) : dly;
        forever begin
            @(negedge clk);
            start = 1'b0;
            bus.blk_done = 1'b0;
            cyc++;
            check_outputs();
            if (frame_done) n_fd++;
            if (!m_busy) break;
            if (cyc > 2000) begin
                check("frame_timeout", cyc, 0);
                break;
            end
            if (abort_idx >= 0 && m_fetch && m_idx == abort_idx) begin
                rst = 1'b0;
                #1;
                check("rst_row_addr", bus.row_addr, 0);
                check("rst_row_valid", bus.row_valid, 0);
                check("rst_blk_first", bus.blk_first, 0);
                check("rst_blk_idx", bus.blk_idx, 0);
                check("rst_busy", busy, 0);
                check("rst_frame_done", frame_done, 0);
                check("rst_proto_err", proto_err, 0);
                @(negedge clk);
                rst = 1'b1;
                model_reset();
                aborted = 1;
                break;
            end
            if (rdy_pct < 0) bus.row_ready = (cyc % 3) != 0;
            else             bus.row_ready = ($urandom_range(1, 100) <= rdy_pct);
            if (m_fetch && $urandom_range(1, 100) <= start_pct) start = 1'b1;
            if (m_fetch && $urandom_range(1, 100) <= err_pct) begin
                bus.blk_done = 1'b1;
                m_proto = 1;
            end
            if (bus.row_valid && bus.row_ready) n_xfer++;
            if (m_fetch) begin
                if (bus.row_ready) begin
                    m_idx++;
                    if (m_idx % FETCH_LEN == 0) begin
                        m_fetch = 0; m_drain = 1; m_dcnt = 0;
                    end
                end
            end else if (m_drain) begin
                if (m_dcnt == d) begin
                    bus.blk_done = 1'b1;
                    m_drain = 0;
                    if (m_idx == TOTAL) m_fdone = 1;
                    else                m_fetch = 1;
                    d = (dly < 0) ? int'($urandom_range(0, 6)) : dly;
                end else begin
                    m_dcnt++;
                end
            end else if (m_fdone) begin
                m_fdone = 0;
                m_busy  = 0;
            end
        end
        bus.blk_done = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            check("transfers", n_xfer, TOTAL);
            check("frame_done_pulses", n_fd, 1);
        end
    endtask

    initial begin
        bus.row_ready = 1'b0;
        bus.blk_done  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check("reset_row_addr", bus.row_addr, 0);
        check("reset_blk_first", bus.blk_first, 0);
        check("reset_blk_idx", bus.blk_idx, 0);
        rst = 1'b1;

        run_frame(100, 5, 0, 0, -1);
        run_frame(-1, 3, 0, 0, -1);
        run_frame(100, -1, 10, 20, -1);

        @(negedge clk);
        bus.blk_done = 1'b1;
        m_proto = 1;
        @(negedge clk);
        bus.blk_done = 1'b0;
        check("idle_blk_done_err", proto_err, 1);

        run_frame(100, 2, 0, 0, FETCH_LEN + 7);
        run_frame(100, 1, 0, 0, -1);
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(50, 100)), -1, 5, 10, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
